// File: rtl/axi_lite_reg_bank.sv
// AXI4-Lite slave register bank: NUM_REGS words, each read/write (driven to fabric)
// or read-only (sampled from hw_status at the read address handshake).
module axi_lite_reg_bank #(
  parameter int                    NUM_REGS   = 8,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic [ADDR_WIDTH-1:0]          S_AWADDR,
  input  logic                           S_AWVALID,
  output logic                           S_AWREADY,
  input  logic [DATA_WIDTH-1:0]          S_WDATA,
  input  logic [DATA_WIDTH/8-1:0]        S_WSTRB,
  input  logic                           S_WVALID,
  output logic                           S_WREADY,
  output logic [1:0]                     S_BRESP,
  output logic                           S_BVALID,
  input  logic                           S_BREADY,
  input  logic [ADDR_WIDTH-1:0]          S_ARADDR,
  input  logic                           S_ARVALID,
  output logic                           S_ARREADY,
  output logic [DATA_WIDTH-1:0]          S_RDATA,
  output logic [1:0]                     S_RRESP,
  output logic                           S_RVALID,
  input  logic                           S_RREADY,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_status,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFFS   = $clog2(STRB_W);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  function automatic int word_idx(input logic [ADDR_WIDTH-1:0] addr);
    return int'(addr >> OFFS);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [STRB_W-1:0]     strb
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_word;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return res;
  endfunction

  w_state_t                w_state;
  r_state_t                r_state;
  logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
  logic [ADDR_WIDTH-1:0]   aw_addr_p0;
  logic [DATA_WIDTH-1:0]   w_data_p0;
  logic [STRB_W-1:0]       w_strb_p0;

  logic                    aw_hs, w_hs, ar_hs;
  logic                    commit;
  logic [ADDR_WIDTH-1:0]   commit_addr;
  logic [DATA_WIDTH-1:0]   commit_data;
  logic [STRB_W-1:0]       commit_strb;
  logic [NUM_REGS-1:0]     wr_sel;
  int                      wr_idx;
  int                      ar_idx;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic                    rd_hit;

  assign aw_hs = S_AWVALID && S_AWREADY;
  assign w_hs  = S_WVALID && S_WREADY;
  assign ar_hs = S_ARVALID && S_ARREADY;

  // Commit takes whichever half of the write was latched earlier plus the half arriving now.
  always_comb begin
    commit      = ((w_state == W_IDLE) && aw_hs && w_hs) ||
                  ((w_state == W_HAVE_ADDR) && w_hs) ||
                  ((w_state == W_HAVE_DATA) && aw_hs);
    commit_addr = (w_state == W_HAVE_ADDR) ? aw_addr_p0 : S_AWADDR;
    commit_data = (w_state == W_HAVE_DATA) ? w_data_p0 : S_WDATA;
    commit_strb = (w_state == W_HAVE_DATA) ? w_strb_p0 : S_WSTRB;
    wr_idx      = word_idx(commit_addr);
    wr_sel      = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_sel[i] = (wr_idx == i) && !RO_MASK[i];
    end
  end

  always_comb begin
    ar_idx  = word_idx(S_ARADDR);
    rd_word = '0;
    rd_hit  = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == i) begin
        rd_hit  = 1'b1;
        rd_word = RO_MASK[i] ? hw_status[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state    <= W_IDLE;
      S_AWREADY  <= 1'b0;
      S_WREADY   <= 1'b0;
      S_BVALID   <= 1'b0;
      S_BRESP    <= RESP_OKAY;
      aw_addr_p0 <= '0;
      w_data_p0  <= '0;
      w_strb_p0  <= '0;
      wr_pulse   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
    end else begin
      wr_pulse <= '0;
      if (commit) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (wr_sel[i]) regs_q[i] <= merge_bytes(regs_q[i], commit_data, commit_strb);
        end
        wr_pulse  <= wr_sel;
        S_BRESP   <= (|wr_sel) ? RESP_OKAY : RESP_SLVERR;
        S_BVALID  <= 1'b1;
        S_AWREADY <= 1'b0;
        S_WREADY  <= 1'b0;
        w_state   <= W_RESP;
      end else begin
        case (w_state)
          W_IDLE: begin
            if (aw_hs) begin
              aw_addr_p0 <= S_AWADDR;
              S_AWREADY  <= 1'b0;
              w_state    <= W_HAVE_ADDR;
            end else if (w_hs) begin
              w_data_p0 <= S_WDATA;
              w_strb_p0 <= S_WSTRB;
              S_WREADY  <= 1'b0;
              w_state   <= W_HAVE_DATA;
            end else begin
              S_AWREADY <= 1'b1;
              S_WREADY  <= 1'b1;
            end
          end
          W_RESP: begin
            if (S_BREADY) begin
              S_BVALID  <= 1'b0;
              S_AWREADY <= 1'b1;
              S_WREADY  <= 1'b1;
              w_state   <= W_IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Read data is captured at the AR handshake and held until the master takes it.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state   <= R_IDLE;
      S_ARREADY <= 1'b0;
      S_RVALID  <= 1'b0;
      S_RDATA   <= '0;
      S_RRESP   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            S_RDATA   <= rd_word;
            S_RRESP   <= rd_hit ? RESP_OKAY : RESP_SLVERR;
            S_RVALID  <= 1'b1;
            S_ARREADY <= 1'b0;
            r_state   <= R_DATA;
          end else begin
            S_ARREADY <= 1'b1;
          end
        end
        R_DATA: begin
          if (S_RREADY) begin
            S_RVALID  <= 1'b0;
            S_ARREADY <= 1'b1;
            r_state   <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[g] ? '0 : regs_q[g];
  end

endmodule

// File: tb/tb_axi_lite_reg_bank.sv
// Directed bench for axi_lite_reg_bank: 8 x 32-bit registers, register 7 read-only.
module tb_axi_lite_reg_bank;
  localparam int NR = 8;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int SW = 4;
  localparam logic [NR-1:0] RO = 8'h80;
  localparam logic [DW-1:0] RV = 32'h5A5A_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [AW-1:0] S_AWADDR = '0;
  logic          S_AWVALID = 1'b0;
  logic          S_AWREADY;
  logic [DW-1:0] S_WDATA = '0;
  logic [SW-1:0] S_WSTRB = '0;
  logic          S_WVALID = 1'b0;
  logic          S_WREADY;
  logic [1:0]    S_BRESP;
  logic          S_BVALID;
  logic          S_BREADY = 1'b0;
  logic [AW-1:0] S_ARADDR = '0;
  logic          S_ARVALID = 1'b0;
  logic          S_ARREADY;
  logic [DW-1:0] S_RDATA;
  logic [1:0]    S_RRESP;
  logic          S_RVALID;
  logic          S_RREADY = 1'b0;
  logic [NR*DW-1:0] hw_status;
  logic [NR*DW-1:0] reg_out;
  logic [NR-1:0]    wr_pulse;

  int n_checks = 0;
  int n_fail = 0;
  int pulse_cnt [NR] = '{default: 0};
  int b_rise = 0;
  logic bvalid_d = 1'b0;

  axi_lite_reg_bank #(
    .NUM_REGS(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RO_MASK(RO), .RESET_VAL(RV)
  ) dut (
    .ACLK(clk), .ARESET(rst),
    .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
    .hw_status(hw_status), .reg_out(reg_out), .wr_pulse(wr_pulse)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int i = 0; i < NR; i++) if (wr_pulse[i] === 1'b1) pulse_cnt[i]++;
    if (S_BVALID === 1'b1 && bvalid_d !== 1'b1) b_rise++;
    bvalid_d = S_BVALID;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int pulse_total();
    int s = 0;
    for (int i = 0; i < NR; i++) s += pulse_cnt[i];
    return s;
  endfunction

  // ---------------- bus tasks (all start and end at posedge+1) ----------------
  task automatic start_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    int t;
    S_AWADDR = a; S_WDATA = d; S_WSTRB = s; S_AWVALID = 1'b1; S_WVALID = 1'b1;
    for (t = 0; t < 20; t++) begin
      @(negedge clk);
      if (S_AWREADY === 1'b1 && S_WREADY === 1'b1) break;
    end
    if (t == 20) begin n_checks++; n_fail++; $display("FAIL aw_w_handshake: timed out, want ready"); end
    @(posedge clk); #1;
    S_AWVALID = 1'b0; S_WVALID = 1'b0;
  endtask

  task automatic send_aw(input logic [AW-1:0] a);
    int t;
    S_AWADDR = a; S_AWVALID = 1'b1;
    for (t = 0; t < 20; t++) begin
      @(negedge clk);
      if (S_AWREADY === 1'b1) break;
    end
    if (t == 20) begin n_checks++; n_fail++; $display("FAIL aw_handshake: timed out, want AWREADY"); end
    @(posedge clk); #1;
    S_AWVALID = 1'b0;
  endtask

  task automatic send_w(input logic [DW-1:0] d, input logic [SW-1:0] s);
    int t;
    S_WDATA = d; S_WSTRB = s; S_WVALID = 1'b1;
    for (t = 0; t < 20; t++) begin
      @(negedge clk);
      if (S_WREADY === 1'b1) break;
    end
    if (t == 20) begin n_checks++; n_fail++; $display("FAIL w_handshake: timed out, want WREADY"); end
    @(posedge clk); #1;
    S_WVALID = 1'b0;
  endtask

  task automatic get_b(output logic [1:0] resp);
    int t;
    for (t = 0; t < 20; t++) begin
      @(negedge clk);
      if (S_BVALID === 1'b1) break;
    end
    if (t == 20) begin n_checks++; n_fail++; $display("FAIL b_wait: timed out, want BVALID"); end
    resp = S_BRESP;
    S_BREADY = 1'b1;
    @(posedge clk); #1;
    S_BREADY = 1'b0;
  endtask

  task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s,
                           output logic [1:0] resp);
    start_write(a, d, s);
    get_b(resp);
  endtask

  task automatic start_read(input logic [AW-1:0] a);
    int t;
    S_ARADDR = a; S_ARVALID = 1'b1;
    for (t = 0; t < 20; t++) begin
      @(negedge clk);
      if (S_ARREADY === 1'b1) break;
    end
    if (t == 20) begin n_checks++; n_fail++; $display("FAIL ar_handshake: timed out, want ARREADY"); end
    @(posedge clk); #1;
    S_ARVALID = 1'b0;
  endtask

  task automatic get_r(output logic [DW-1:0] d, output logic [1:0] resp, output int lat);
    int t;
    for (t = 1; t <= 20; t++) begin
      @(negedge clk);
      if (S_RVALID === 1'b1) break;
    end
    if (t > 20) begin n_checks++; n_fail++; $display("FAIL r_wait: timed out, want RVALID"); end
    lat = t; d = S_RDATA; resp = S_RRESP;
    S_RREADY = 1'b1;
    @(posedge clk); #1;
    S_RREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic [1:0] resp,
                          output int lat);
    start_read(a);
    get_r(d, resp, lat);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [DW-1:0] d; logic [1:0] r; int lat;
    repeat (2) @(posedge clk); #1;
    n_checks++; if (S_AWREADY !== 1'b0 || S_WREADY !== 1'b0 || S_ARREADY !== 1'b0) begin n_fail++;
      $display("FAIL reset_ready: got aw=%b w=%b ar=%b want 000", S_AWREADY, S_WREADY, S_ARREADY); end
    n_checks++; if (S_BVALID !== 1'b0 || S_RVALID !== 1'b0 || S_BRESP !== 2'b00 || S_RRESP !== 2'b00) begin n_fail++;
      $display("FAIL reset_valid: got bv=%b rv=%b br=%b rr=%b want 0 0 00 00", S_BVALID, S_RVALID, S_BRESP, S_RRESP); end
    n_checks++; if (S_RDATA !== 32'h0 || wr_pulse !== 8'h00) begin n_fail++;
      $display("FAIL reset_rdata_pulse: got rdata=%h pulse=%h want 0 0", S_RDATA, wr_pulse); end
    n_checks++; if (reg_out[0 +: DW] !== RV || reg_out[7*DW +: DW] !== 32'h0) begin n_fail++;
      $display("FAIL reset_reg_out: got r0=%h r7=%h want %h 0", reg_out[0 +: DW], reg_out[7*DW +: DW], RV); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (S_AWREADY !== 1'b1 || S_WREADY !== 1'b1 || S_ARREADY !== 1'b1) begin n_fail++;
      $display("FAIL idle_ready: got aw=%b w=%b ar=%b want 111", S_AWREADY, S_WREADY, S_ARREADY); end
    axi_read(8'h08, d, r, lat);
    n_checks++; if (d !== RV || r !== 2'b00) begin n_fail++;
      $display("FAIL reset_readback: got %h/%b want %h/00", d, r, RV); end
  endtask

  task automatic test_basic_rw();
    logic [DW-1:0] d; logic [1:0] r; int lat; int base [NR]; logic [7:0] exp_p;
    for (int i = 0; i < NR; i++) base[i] = pulse_cnt[i];
    for (int i = 0; i < 4; i++) begin
      start_write(8'(i * 4), DW'(i + 1), 4'hF);
      exp_p = 8'h01 << i;
      @(negedge clk);
      n_checks++; if (wr_pulse !== exp_p) begin n_fail++;
        $display("FAIL pulse_next_cycle[%0d]: got %h want %h", i, wr_pulse, exp_p); end
      @(negedge clk);
      n_checks++; if (wr_pulse !== 8'h00) begin n_fail++;
        $display("FAIL pulse_one_cycle[%0d]: got %h want 00", i, wr_pulse); end
      get_b(r);
      n_checks++; if (r !== 2'b00) begin n_fail++; $display("FAIL basic_bresp[%0d]: got %b want 00", i, r); end
    end
    for (int i = 0; i < NR; i++) begin
      n_checks++; if (pulse_cnt[i] - base[i] !== ((i < 4) ? 1 : 0)) begin n_fail++;
        $display("FAIL basic_pulse_count[%0d]: got %0d want %0d", i, pulse_cnt[i] - base[i], (i < 4) ? 1 : 0); end
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(8'(i * 4), d, r, lat);
      n_checks++; if (d !== DW'(i + 1) || r !== 2'b00) begin n_fail++;
        $display("FAIL basic_read[%0d]: got %h/%b want %h/00", i, d, r, i + 1); end
      n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL read_latency[%0d]: got %0d want 1", i, lat); end
      n_checks++; if (reg_out[i*DW +: DW] !== DW'(i + 1)) begin n_fail++;
        $display("FAIL basic_reg_out[%0d]: got %h want %h", i, reg_out[i*DW +: DW], i + 1); end
    end
  endtask

  task automatic test_strobe();
    logic [DW-1:0] d; logic [1:0] r; int lat; int p;
    axi_write(8'h10, 32'hAABBCCDD, 4'hF, r);
    axi_write(8'h10, 32'h11223344, 4'b0101, r);
    n_checks++; if (r !== 2'b00) begin n_fail++; $display("FAIL strobe_bresp: got %b want 00", r); end
    axi_read(8'h10, d, r, lat);
    n_checks++; if (d !== 32'hAA22CC44 || r !== 2'b00) begin n_fail++;
      $display("FAIL strobe_merge: got %h/%b want aa22cc44/00", d, r); end
    p = pulse_cnt[4];
    axi_write(8'h12, 32'hFFFFFFFF, 4'h0, r);
    n_checks++; if (r !== 2'b00 || pulse_cnt[4] - p !== 1) begin n_fail++;
      $display("FAIL strobe_zero_resp_pulse: got %b/%0d want 00/1", r, pulse_cnt[4] - p); end
    axi_read(8'h10, d, r, lat);
    n_checks++; if (d !== 32'hAA22CC44) begin n_fail++; $display("FAIL strobe_zero_data: got %h want aa22cc44", d); end
  endtask

  task automatic test_staggered();
    logic [DW-1:0] d; logic [1:0] r; int lat; int b0;
    b0 = b_rise;
    send_aw(8'h14);
    @(negedge clk);
    n_checks++; if (S_AWREADY !== 1'b0 || S_WREADY !== 1'b1 || S_BVALID !== 1'b0) begin n_fail++;
      $display("FAIL have_addr_ready: got aw=%b w=%b bv=%b want 0 1 0", S_AWREADY, S_WREADY, S_BVALID); end
    @(posedge clk); #1; @(posedge clk); #1;
    send_w(32'h0000_0055, 4'hF);
    get_b(r);
    n_checks++; if (r !== 2'b00 || b_rise - b0 !== 1) begin n_fail++;
      $display("FAIL aw_first_commit: got %b/%0d responses want 00/1", r, b_rise - b0); end
    axi_read(8'h14, d, r, lat);
    n_checks++; if (d !== 32'h55) begin n_fail++; $display("FAIL aw_first_data: got %h want 55", d); end
    b0 = b_rise;
    send_w(32'h0000_0066, 4'hF);
    @(negedge clk);
    n_checks++; if (S_AWREADY !== 1'b1 || S_WREADY !== 1'b0 || S_BVALID !== 1'b0) begin n_fail++;
      $display("FAIL have_data_ready: got aw=%b w=%b bv=%b want 1 0 0", S_AWREADY, S_WREADY, S_BVALID); end
    @(posedge clk); #1; @(posedge clk); #1;
    send_aw(8'h18);
    get_b(r);
    n_checks++; if (r !== 2'b00 || b_rise - b0 !== 1) begin n_fail++;
      $display("FAIL w_first_commit: got %b/%0d responses want 00/1", r, b_rise - b0); end
    axi_read(8'h18, d, r, lat);
    n_checks++; if (d !== 32'h66) begin n_fail++; $display("FAIL w_first_data: got %h want 66", d); end
  endtask

  task automatic test_ro();
    logic [DW-1:0] d; logic [1:0] r; int lat; int p;
    p = pulse_total();
    axi_write(8'h1C, 32'h5, 4'hF, r);
    n_checks++; if (r !== 2'b10 || pulse_total() - p !== 0) begin n_fail++;
      $display("FAIL ro_write: got %b/%0d pulses want 10/0", r, pulse_total() - p); end
    axi_read(8'h1C, d, r, lat);
    n_checks++; if (d !== 32'hDEADBEEF || r !== 2'b00) begin n_fail++;
      $display("FAIL ro_read: got %h/%b want deadbeef/00", d, r); end
    n_checks++; if (reg_out[7*DW +: DW] !== 32'h0) begin n_fail++;
      $display("FAIL ro_reg_out: got %h want 0", reg_out[7*DW +: DW]); end
    start_read(8'h1C);
    hw_status[7*DW +: DW] = 32'h0BADF00D;
    @(negedge clk);
    n_checks++; if (S_RDATA !== 32'hDEADBEEF) begin n_fail++;
      $display("FAIL ro_sample_hold: got %h want deadbeef", S_RDATA); end
    @(posedge clk); #1;
    get_r(d, r, lat);
    axi_read(8'h1C, d, r, lat);
    n_checks++; if (d !== 32'h0BADF00D) begin n_fail++; $display("FAIL ro_resample: got %h want 0badf00d", d); end
  endtask

  task automatic test_out_of_range();
    logic [DW-1:0] d; logic [1:0] r; int lat; int p; logic [NR*DW-1:0] exp_out;
    exp_out = {32'h0, 32'h66, 32'h55, 32'hAA22CC44, 32'h4, 32'h3, 32'h2, 32'h1};
    p = pulse_total();
    axi_write(8'h20, 32'h77, 4'hF, r);
    n_checks++; if (r !== 2'b10 || pulse_total() - p !== 0) begin n_fail++;
      $display("FAIL oor_write: got %b/%0d pulses want 10/0", r, pulse_total() - p); end
    axi_write(8'h23, 32'h77, 4'hF, r);
    n_checks++; if (r !== 2'b10) begin n_fail++; $display("FAIL oor_write_offset: got %b want 10", r); end
    n_checks++; if (reg_out !== exp_out) begin n_fail++;
      $display("FAIL oor_no_change: got %h want %h", reg_out, exp_out); end
    axi_read(8'h20, d, r, lat);
    n_checks++; if (d !== 32'h0 || r !== 2'b10) begin n_fail++; $display("FAIL oor_read: got %h/%b want 0/10", d, r); end
    axi_read(8'hFC, d, r, lat);
    n_checks++; if (d !== 32'h0 || r !== 2'b10) begin n_fail++; $display("FAIL oor_read_top: got %h/%b want 0/10", d, r); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d; logic [1:0] r, br; int lat;
    fork
      start_write(8'h00, 32'h99, 4'hF);
      start_read(8'h00);
    join
    fork
      get_b(br);
      get_r(d, r, lat);
    join
    n_checks++; if (d !== 32'h1 || r !== 2'b00 || br !== 2'b00) begin n_fail++;
      $display("FAIL same_cycle_read: got %h/%b bresp %b want 1/00 bresp 00", d, r, br); end
    axi_read(8'h00, d, r, lat);
    n_checks++; if (d !== 32'h99) begin n_fail++; $display("FAIL same_cycle_after: got %h want 99", d); end
  endtask

  task automatic test_hold_and_reset();
    logic [DW-1:0] d; logic [1:0] r; int lat;
    start_write(8'h14, 32'h12345678, 4'hF);
    start_read(8'h14);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++; if (S_BVALID !== 1'b1 || S_BRESP !== 2'b00) begin n_fail++;
        $display("FAIL b_hold[%0d]: got bv=%b br=%b want 1 00", k, S_BVALID, S_BRESP); end
      n_checks++; if (S_RVALID !== 1'b1 || S_RDATA !== 32'h12345678 || S_RRESP !== 2'b00) begin n_fail++;
        $display("FAIL r_hold[%0d]: got rv=%b %h/%b want 1 12345678/00", k, S_RVALID, S_RDATA, S_RRESP); end
    end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_checks++; if (S_BVALID !== 1'b0 || S_RVALID !== 1'b0 || S_AWREADY !== 1'b0 || S_ARREADY !== 1'b0) begin n_fail++;
      $display("FAIL midreset_ctrl: got bv=%b rv=%b aw=%b ar=%b want 0000", S_BVALID, S_RVALID, S_AWREADY, S_ARREADY); end
    n_checks++; if (reg_out[5*DW +: DW] !== RV || reg_out[0 +: DW] !== RV || wr_pulse !== 8'h00) begin n_fail++;
      $display("FAIL midreset_regs: got r5=%h r0=%h pulse=%h want %h %h 00", reg_out[5*DW +: DW], reg_out[0 +: DW], wr_pulse, RV, RV); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (S_AWREADY !== 1'b1 || S_ARREADY !== 1'b1 || S_BVALID !== 1'b0) begin n_fail++;
      $display("FAIL post_reset_idle: got aw=%b ar=%b bv=%b want 1 1 0", S_AWREADY, S_ARREADY, S_BVALID); end
    axi_read(8'h14, d, r, lat);
    n_checks++; if (d !== RV || r !== 2'b00) begin n_fail++;
      $display("FAIL post_reset_read: got %h/%b want %h/00", d, r, RV); end
  endtask

  initial begin
    hw_status = '0;
    for (int i = 0; i < NR; i++) hw_status[i*DW +: DW] = 32'h1000 + i;
    hw_status[7*DW +: DW] = 32'hDEADBEEF;
    test_reset();
    test_basic_rw();
    test_strobe();
    test_staggered();
    test_ro();
    test_out_of_range();
    test_back_to_back();
    test_hold_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_lite_reg_bank.md
Name: axi_lite_reg_bank

Overview:
Parametrised AXI4-Lite slave register bank. It is the successor to the fixed four-register index IP and replaces hard-coded register slots with a configurable count and width. Each register is either read/write (driven to fabric) or read-only (sampled from fabric status), selected per register by a mask. It adds byte strobes, error responses for illegal accesses and one-cycle write-notify pulses, so music/game logic can react to CPU writes.

Parameters:
NUM_REGS, 8, number of registers (2..64)
DATA_WIDTH, 32, register/bus width (32 or 64)
ADDR_WIDTH, 8, AXI address width; must satisfy 2^ADDR_WIDTH >= NUM_REGS*DATA_WIDTH/8
RO_MASK, 0, NUM_REGS-bit mask; bit i=1 makes register i read-only
RESET_VAL, 0, reset value of every R/W register

Ports:
ACLK  in  1  bus clock
ARESET  in  1  asynchronous active-high reset
S_AWADDR  in  ADDR_WIDTH  write address
S_AWVALID  in  1  write address valid
S_AWREADY  out  1  write address ready
S_WDATA  in  DATA_WIDTH  write data
S_WSTRB  in  DATA_WIDTH/8  byte strobes
S_WVALID  in  1  write data valid
S_WREADY  out  1  write data ready
S_BRESP  out  2  write response
S_BVALID  out  1  write response valid
S_BREADY  in  1  write response ready
S_ARADDR  in  ADDR_WIDTH  read address
S_ARVALID  in  1  read address valid
S_ARREADY  out  1  read address ready
S_RDATA  out  DATA_WIDTH  read data
S_RRESP  out  2  read response
S_RVALID  out  1  read data valid
S_RREADY  in  1  read data ready
hw_status  in  NUM_REGS*DATA_WIDTH  read values for RO registers (reg i at bits i*DATA_WIDTH+:DATA_WIDTH)
reg_out  out  NUM_REGS*DATA_WIDTH  current R/W register contents (RO slots drive 0)
wr_pulse  out  NUM_REGS  one-cycle pulse per successful register write

Behaviour:
- Reset (async assert, sync release): all READY/VALID outputs 0, BRESP/RRESP 0, RDATA 0, R/W registers = RESET_VAL, wr_pulse 0.
- Word index = addr >> log2(DATA_WIDTH/8); low byte-offset bits ignored.
- Write FSM states: W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP.
  - W_IDLE: AWREADY=WREADY=1. AW-only handshake -> W_HAVE_ADDR (latch addr). W-only -> W_HAVE_DATA (latch data/strb). Both in same cycle -> commit -> W_RESP.
  - W_HAVE_ADDR: AWREADY=0, WREADY=1; on W handshake commit -> W_RESP. W_HAVE_DATA symmetric.
  - Commit cycle: if index < NUM_REGS and RO_MASK[index]=0, update bytes with WSTRB=1, BRESP=OKAY (00), and wr_pulse[index]=1 on the next cycle for exactly one cycle. Otherwise (out of range or RO): no update, no pulse, BRESP=SLVERR (10). WSTRB=0 on a writable register gives OKAY, no byte change, pulse still asserted.
  - W_RESP: BVALID=1, held with BRESP stable until BREADY -> W_IDLE. No new AW/W accepted while in W_RESP.
- Read FSM states: R_IDLE (ARREADY=1), R_DATA (RVALID=1).
  - AR handshake: RDATA registered the same edge; RW reg -> register value, RO reg -> hw_status slice, out of range -> 0 with RRESP=SLVERR, else OKAY. Read latency 1 cycle from AR handshake to RVALID.
  - RDATA/RRESP stable while RVALID && !RREADY; on RREADY -> R_IDLE.
- Read and write channels are independent. A read accepted in the same cycle as a write commit to the same register returns the pre-write value.
- hw_status is sampled only at AR handshake, not continuously.
- Reset mid-transaction: all in-flight transfers are dropped, FSMs return to idle, registers return to RESET_VAL.

Test Plan:
- Write 0x1,0x2,0x3,0x4 to 0x00,0x04,0x08,0x0C, then read back -> each RDATA matches, RRESP=00, wr_pulse[0..3] each high exactly 1 cycle.
- Write 0xAABBCCDD then 0x11223344 with WSTRB=0101 to 0x10 -> read 0xAA22CC44.
- AW presented 3 cycles before W, and separately W 3 cycles before AW -> single commit, one BVALID, BRESP=00.
- RO_MASK=0x80, hw_status reg7=0xDEADBEEF: write 0x5 to 0x1C -> BRESP=10, no pulse; read 0x1C -> 0xDEADBEEF, RRESP=00.
- Read/write 0x20 with NUM_REGS=8 -> BRESP=10, RDATA=0, RRESP=10, no register changes.
- Hold BREADY/RREADY low 5 cycles -> BVALID/RVALID and data held stable; assert ARESET mid-hold -> all valids 0, reg_out=RESET_VAL.
